omsp_spm_alloc_ctrl: RTL
========================

// Module: omsp_spm_alloc_ctrl
// PURPOSE
// Parametrised protected-module (SPM) allocation controller. It replaces the single-cycle
// parallel overlap check with a sequenced scan: one SPM slot per cycle, under a req/done
// handshake. It owns ID allocation and exhaustion, and tracks the current/previous
// executing-module ID. It sits between the execution unit (protect/unprotect requests)
// and the array of omsp_spm slot instances.
// PARAMETERS
// NB_SPMS      4         number of SPM slots (1..16)
// ID_W         16        width of module IDs and of the next-ID counter
// IRQ_W        4         width of irq_num
// IRQ_ID_BASE  16'hfff0  first reserved IRQ ID; allocation stops here (ID_W bits)
// PORTS
// mclk             in   1             core clock
// puc_rst          in   1             async active-high reset
// req_valid        in   1             protect/unprotect request, sampled when req_ready=1
// req_enable       in   1             1=create SPM, 0=destroy (all slots self-select)
// req_ready        out  1             controller idle, can accept a request
// done             out  1             1-cycle pulse: request finished
// result_ok        out  1             valid with done: 1=success, 0=violation/reject
// slot_enabled     in   NB_SPMS       per-slot enabled flags from the slot array
// slot_overlap     in   NB_SPMS       per-slot overlap verdict for the slot under check_sel
// slot_check       out  NB_SPMS       one-hot: slot asked to compare against new layout
// slot_update      out  NB_SPMS       slot write strobe (one-hot create, all-ones destroy)
// next_id          out  ID_W          ID the next created SPM receives
// id_exhausted     out  1             next_id == IRQ_ID_BASE
// slot_executing   in   NB_SPMS       per-slot "pc inside my text section"
// slot_id          in   NB_SPMS*ID_W  slot IDs, slot i at [i*ID_W +: ID_W]
// handling_irq     in   1             core is in interrupt entry
// irq_num          in   IRQ_W         active IRQ number
// spm_current_id   out  ID_W          ID of the executing context
// spm_prev_id      out  ID_W          ID of the context executing before the last switch
// enter_sm         out  1             current ID differs from the previous cycle
// BEHAVIOUR
// - Reset: FSM=IDLE, req_ready=1, done=0, result_ok=0, slot_check=0, slot_update=0,
//   next_id=1, spm_prev_id=0, prev-cycle ID register=0.
// - FSM states: IDLE, SCAN, COMMIT, FINISH.
//   - IDLE: req_ready=1. Accept when req_valid=1.
//     - Create: latch target = first slot with slot_enabled=0 (lowest index).
//       - No free slot, or id_exhausted -> FINISH with fail.
//       - Otherwise -> SCAN with idx=0.
//     - Destroy: -> COMMIT.
//   - SCAN: one cycle per idx, 0..NB_SPMS-1.
//     - slot_check[idx]=1 only if slot_enabled[idx] && idx!=target; otherwise idle cycle.
//     - slot_overlap[idx]=1 in the same cycle while checked -> FINISH with fail (abort).
//     - Otherwise: at idx=NB_SPMS-1 -> COMMIT, else idx+1.
//   - COMMIT: one cycle. slot_update = create ? onehot(target) : all-ones.
//     On create, next_id increments at the clock edge. -> FINISH with ok.
//   - FINISH: done=1 and result_ok per latched verdict, for one cycle. -> IDLE.
// - Latency (accept edge to done): successful create = NB_SPMS+2 cycles; destroy = 2 cycles;
//   reject = 1 cycle; overlap abort = idx+2 cycles.
// - req_valid while req_ready=0 is ignored, not queued.
// - A new request is accepted in the cycle after done.
// - next_id saturates at IRQ_ID_BASE and never wraps. Further creates are rejected.
// - Current ID (combinational):
//   - handling_irq=1: IRQ_ID_BASE + irq_num, ID_W-bit add.
//   - Else: slot_id of the highest-index executing slot.
//   - Else: 0.
// - prev-cycle ID register loads spm_current_id every cycle. enter_sm = (reg != current).
//   spm_prev_id <= prev-cycle reg whenever enter_sm=1.
// - puc_rst mid-operation: FSM returns to IDLE. No slot_update or done is issued.
// - slot_check and slot_update are never both non-zero in the same cycle.
// TESTING (NB_SPMS=4)
// - Create, slots 0,1 enabled, no overlap -> check 0001, 0010, 0000, 0000; update 0100;
//   done+ok at accept+6; next_id 1->2.
// - Create, slot_overlap[1]=1 at idx1 -> abort; done with ok=0 at accept+3;
//   no update; next_id unchanged.
// - Create, all slots enabled -> done with ok=0 at accept+1; slot_check stays 0.
// - Destroy -> slot_update=1111 for one cycle; done+ok at accept+2.
// - Force next_id=16'hffef, create twice -> first succeeds (id_exhausted=1),
//   second is rejected.
// - slot2 executing with id 5, then handling_irq with irq_num=3 -> current 5 -> fff3;
//   enter_sm pulses; spm_prev_id=5. Also assert reset during SCAN -> IDLE, no done.

Source files
------------

// File: rtl/omsp_spm_alloc_ctrl.sv
// Sequenced protected-module allocation controller: scans one SPM slot per cycle for
// layout overlap, owns module-ID allocation and tracks the executing-module ID.
module omsp_spm_alloc_ctrl #(
  parameter int              NB_SPMS     = 4,
  parameter int              ID_W        = 16,
  parameter int              IRQ_W       = 4,
  parameter logic [ID_W-1:0] IRQ_ID_BASE = 16'hfff0
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    req_valid,
  input  logic                    req_enable,
  output logic                    req_ready,
  output logic                    done,
  output logic                    result_ok,
  input  logic [NB_SPMS-1:0]      slot_enabled,
  input  logic [NB_SPMS-1:0]      slot_overlap,
  output logic [NB_SPMS-1:0]      slot_check,
  output logic [NB_SPMS-1:0]      slot_update,
  output logic [ID_W-1:0]         next_id,
  output logic                    id_exhausted,
  input  logic [NB_SPMS-1:0]      slot_executing,
  input  logic [NB_SPMS*ID_W-1:0] slot_id,
  input  logic                    handling_irq,
  input  logic [IRQ_W-1:0]        irq_num,
  output logic [ID_W-1:0]         spm_current_id,
  output logic [ID_W-1:0]         spm_prev_id,
  output logic                    enter_sm
);

  localparam int IDX_W = (NB_SPMS > 1) ? $clog2(NB_SPMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_SPMS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic [IDX_W-1:0]  target_r, target_s;
  logic              create_r, create_s;
  logic              ok_r, ok_s;
  logic [ID_W-1:0]   next_id_r;
  logic [ID_W-1:0]   prev_cycle_id_r;
  logic [ID_W-1:0]   spm_prev_id_r;
  logic              free_found_s;
  logic [IDX_W-1:0]  free_idx_s;
  logic              id_inc_s;
  logic              checking_s;
  logic [NB_SPMS-1:0] slot_check_s, slot_update_s;
  logic [ID_W-1:0]   exec_id_s, current_id_s;

  // Lowest-index free slot: walk downwards so the lowest hit is written last.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = NB_SPMS - 1; i >= 0; i--) begin
      free_found_s = slot_enabled[i] ? free_found_s : 1'b1;
      free_idx_s   = slot_enabled[i] ? free_idx_s : IDX_W'(i);
    end
  end

  assign id_exhausted = (next_id_r == IRQ_ID_BASE);

  // Next-state and strobe decode for the allocation sequencer.
  always_comb begin
    state_s       = state_r;
    idx_s         = idx_r;
    target_s      = target_r;
    create_s      = create_r;
    ok_s          = ok_r;
    id_inc_s      = 1'b0;
    checking_s    = 1'b0;
    slot_check_s  = '0;
    slot_update_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          create_s = req_enable;
          if (!req_enable) begin
            state_s = ST_COMMIT;
          end else if (!free_found_s || id_exhausted) begin
            ok_s    = 1'b0;
            state_s = ST_FINISH;
          end else begin
            target_s = free_idx_s;
            idx_s    = '0;
            state_s  = ST_SCAN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        checking_s = slot_enabled[idx_r] && (idx_r != target_r);
        if (checking_s) begin
          slot_check_s[idx_r] = 1'b1;
        end else begin
          slot_check_s = '0;
        end
        if (checking_s && slot_overlap[idx_r]) begin
          ok_s    = 1'b0;
          state_s = ST_FINISH;
        end else if (idx_r == LAST_IDX) begin
          state_s = ST_COMMIT;
        end else begin
          idx_s = idx_r + IDX_W'(1);
        end
      end
      ST_COMMIT: begin
        if (create_r) begin
          slot_update_s[target_r] = 1'b1;
          id_inc_s                = 1'b1;
        end else begin
          slot_update_s = '1;
        end
        ok_s    = 1'b1;
        state_s = ST_FINISH;
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and latched request context.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_r  <= ST_IDLE;
      idx_r    <= '0;
      target_r <= '0;
      create_r <= 1'b0;
      ok_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      target_r <= target_s;
      create_r <= create_s;
      ok_r     <= ok_s;
    end
  end

  // Next-ID counter saturates at the reserved IRQ range and never wraps.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      next_id_r <= ID_W'(1);
    end else if (id_inc_s && (next_id_r != IRQ_ID_BASE)) begin
      next_id_r <= next_id_r + ID_W'(1);
    end
  end

  assign req_ready   = (state_r == ST_IDLE);
  assign done        = (state_r == ST_FINISH);
  assign result_ok   = (state_r == ST_FINISH) && ok_r;
  assign slot_check  = slot_check_s;
  assign slot_update = slot_update_s;
  assign next_id     = next_id_r;

  // Executing-context ID: the highest-index executing slot wins.
  always_comb begin
    exec_id_s = '0;
    for (int i = 0; i < NB_SPMS; i++) begin
      exec_id_s = slot_executing[i] ? slot_id[i*ID_W +: ID_W] : exec_id_s;
    end
    if (handling_irq) begin
      current_id_s = IRQ_ID_BASE + ID_W'(irq_num);
    end else begin
      current_id_s = exec_id_s;
    end
  end

  assign spm_current_id = current_id_s;
  assign enter_sm       = (prev_cycle_id_r != current_id_s);

  // Previous-context tracking across module switches.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      prev_cycle_id_r <= '0;
      spm_prev_id_r   <= '0;
    end else begin
      prev_cycle_id_r <= current_id_s;
      if (enter_sm) begin
        spm_prev_id_r <= prev_cycle_id_r;
      end
    end
  end

  assign spm_prev_id = spm_prev_id_r;

endmodule
